stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/bcd_digit_pair.sv | 53 +++++
 rtl/stopwatch_counter.sv | 194 +++++++++++++++++++
 tb/tb_stopwatch_counter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter.
// Optional feature macro used by stopwatch_counter: STOPWATCH_LAP_EN.
package stopwatch_pkg;

   // state       | meaning
   // ST_IDLE     | count zeroed, waiting for startStop
   // ST_RUNNING  | ticks advance the count
   // ST_PAUSED   | count held, ticks discarded
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2
   } sw_state_e;

   typedef logic [3:0] bcd_t;

   localparam int unsigned HUN_MAX = 99;
   localparam int unsigned SEC_MAX = 59;

   // Binary value 0..99 to a packed pair of BCD digits {tens, ones}.
   function automatic logic [7:0] to_bcd2(input int unsigned v);
      logic [7:0] r;
      r[7:4] = 4'((v / 10) % 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter 00..MAX_VAL. Steps when i_inc and i_cin are both high;
// o_cout flags the step that wraps the pair back to 00 so pairs can be cascaded.
module bcd_digit_pair
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX_VAL = 99
)
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   input  logic i_cin,
   output bcd_t o_tens,
   output bcd_t o_ones,
   output logic o_cout
);

   localparam logic [7:0] MAX_BCD = to_bcd2(MAX_VAL);

   bcd_t r_tens;
   bcd_t r_ones;
   logic w_at_max;
   logic w_step;

   assign w_at_max = ({r_tens, r_ones} == MAX_BCD);
   assign w_step   = i_inc & i_cin;
   assign o_cout   = w_step & w_at_max;
   assign o_tens   = r_tens;
   assign o_ones   = r_ones;

   // Digit registers: synchronous clear has priority over stepping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tens <= 4'd0;
         r_ones <= 4'd0;
      end else if (i_clr) begin
         r_tens <= 4'd0;
         r_ones <= 4'd0;
      end else if (w_step) begin
         if (w_at_max) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
         end else if (r_ones == 4'd9) begin
            r_ones <= 4'd0;
            r_tens <= r_tens + 4'd1;
         end else begin
            r_ones <= r_ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch: synchronized 100 Hz tick, run/pause FSM, MM:SS.hh BCD count.
// Optional lap/freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MINUTE_WRAP = 60
)
(
   input  logic inClock,
   input  logic reset,
   input  logic tickIn,
   input  logic startStop,
   input  logic clear,
   input  logic lap,
   output bcd_t minTens,
   output bcd_t minOnes,
   output bcd_t secTens,
   output bcd_t secOnes,
   output bcd_t hunTens,
   output bcd_t hunOnes,
   output logic running,
   output logic lapActive,
   output logic rollover
);

   // state       | meaning
   // ST_IDLE     | count zeroed, waiting for startStop
   // ST_RUNNING  | ticks advance the count
   // ST_PAUSED   | count held, ticks discarded

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("stopwatch_counter: SYNC_STAGES must be 2..3");
   end
   if (MINUTE_WRAP < 1 || MINUTE_WRAP > 99) begin : g_bad_wrap
      $error("stopwatch_counter: MINUTE_WRAP must be 1..99");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_hist;
   logic                   r_seen_low;
   logic                   w_synced;
   logic                   w_tick;

   sw_state_e r_state;
   sw_state_e w_state_next;
   logic      w_count_en;

   logic r_running;
   logic r_rollover;

   bcd_t w_min_t, w_min_o, w_sec_t, w_sec_o, w_hun_t, w_hun_o;
   logic w_hun_cout, w_sec_cout, w_min_cout;
   logic [23:0] w_live;

   assign w_synced = r_sync[SYNC_STAGES-1];
   // A rising edge only counts once a real low sample has come through the
   // chain, so tickIn held high across reset release is not taken as a tick.
   assign w_tick   = w_synced & ~r_hist & r_seen_low;

   // Synchronizer, history flop and the "seen a real low" qualifier.
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         r_sync     <= '0;
         r_fill     <= '0;
         r_hist     <= 1'b0;
         r_seen_low <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SYNC_STAGES-2:0], tickIn};
         r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_hist     <= w_synced;
         r_seen_low <= r_seen_low | (r_fill[SYNC_STAGES-1] & ~w_synced);
      end
   end

   // FSM state register.
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and count enable; clear overrides everything, and the count
   // decision uses the current state so a tick with startStop counts only when
   // leaving RUNNING.
   always_comb begin
      w_state_next = r_state;
      w_count_en   = 1'b0;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         w_count_en = w_tick & (r_state == ST_RUNNING);
         if (startStop) begin
            case (r_state)
               ST_IDLE:    w_state_next = ST_RUNNING;
               ST_RUNNING: w_state_next = ST_PAUSED;
               ST_PAUSED:  w_state_next = ST_RUNNING;
               default:    w_state_next = ST_IDLE;
            endcase
         end
      end
   end

   bcd_digit_pair #(.MAX_VAL(HUN_MAX)) u_hun (
      .i_clk   (inClock),
      .i_rst_n (reset),
      .i_clr   (clear),
      .i_inc   (w_count_en),
      .i_cin   (1'b1),
      .o_tens  (w_hun_t),
      .o_ones  (w_hun_o),
      .o_cout  (w_hun_cout)
   );

   bcd_digit_pair #(.MAX_VAL(SEC_MAX)) u_sec (
      .i_clk   (inClock),
      .i_rst_n (reset),
      .i_clr   (clear),
      .i_inc   (w_count_en),
      .i_cin   (w_hun_cout),
      .o_tens  (w_sec_t),
      .o_ones  (w_sec_o),
      .o_cout  (w_sec_cout)
   );

   bcd_digit_pair #(.MAX_VAL(MINUTE_WRAP - 1)) u_min (
      .i_clk   (inClock),
      .i_rst_n (reset),
      .i_clr   (clear),
      .i_inc   (w_count_en),
      .i_cin   (w_sec_cout),
      .o_tens  (w_min_t),
      .o_ones  (w_min_o),
      .o_cout  (w_min_cout)
   );

   assign w_live = {w_min_t, w_min_o, w_sec_t, w_sec_o, w_hun_t, w_hun_o};

   // Registered status outputs; the minute carry-out is the full wrap.
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         r_running  <= 1'b0;
         r_rollover <= 1'b0;
      end else begin
         r_running  <= (w_state_next == ST_RUNNING);
         r_rollover <= w_min_cout;
      end
   end

   assign running  = r_running;
   assign rollover = r_rollover;

`ifdef STOPWATCH_LAP_EN
   logic        r_lap_active;
   logic [23:0] r_disp;
   logic [23:0] w_show;

   // Lap toggles only while running; a lap in IDLE/PAUSED releases the freeze.
   // The display capture is the count before any tick of the same cycle.
   always_ff @(posedge inClock or negedge reset) begin
      if (!reset) begin
         r_lap_active <= 1'b0;
         r_disp       <= '0;
      end else if (clear) begin
         r_lap_active <= 1'b0;
         r_disp       <= '0;
      end else if (lap) begin
         if (r_state == ST_RUNNING) begin
            r_lap_active <= ~r_lap_active;
            if (!r_lap_active) begin
               r_disp <= w_live;
            end
         end else begin
            r_lap_active <= 1'b0;
         end
      end
   end

   // Output select between two register sets; no input reaches the outputs.
   assign w_show    = r_lap_active ? r_disp : w_live;
   assign lapActive = r_lap_active;
   assign {minTens, minOnes, secTens, secOnes, hunTens, hunOnes} = w_show;
`else
   logic w_lap_unused;

   assign w_lap_unused = lap;
   assign lapActive    = 1'b0;
   assign {minTens, minOnes, secTens, secOnes, hunTens, hunOnes} = w_live;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter, built with MINUTE_WRAP=2 so the
// minute carry and the full wrap are both reachable in a short run.
module tb_stopwatch_counter;

   logic       inClock;
   logic       reset;
   logic       tickIn;
   logic       startStop;
   logic       clear;
   logic       lap;
   logic [3:0] minTens, minOnes, secTens, secOnes, hunTens, hunOnes;
   logic       running;
   logic       lapActive;
   logic       rollover;

   int checks;
   int errors;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_ON = 1'b1;
`else
   localparam bit LAP_ON = 1'b0;
`endif

   stopwatch_counter #(.SYNC_STAGES(2), .MINUTE_WRAP(2)) dut (
      .inClock   (inClock),
      .reset     (reset),
      .tickIn    (tickIn),
      .startStop (startStop),
      .clear     (clear),
      .lap       (lap),
      .minTens   (minTens),
      .minOnes   (minOnes),
      .secTens   (secTens),
      .secOnes   (secOnes),
      .hunTens   (hunTens),
      .hunOnes   (hunOnes),
      .running   (running),
      .lapActive (lapActive),
      .rollover  (rollover)
   );

   initial inClock = 1'b0;
   always #10 inClock = ~inClock;

   function automatic logic [23:0] digits();
      return {minTens, minOnes, secTens, secOnes, hunTens, hunOnes};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // n fast ticks, one rising edge every two cycles, then let the chain drain.
   task automatic pre_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         tickIn = 1'b1;
         @(negedge inClock);
         tickIn = 1'b0;
         @(negedge inClock);
      end
      @(negedge inClock);
      @(negedge inClock);
   endtask

   // One step: optional tick whose detect cycle coincides with the pulses.
   // ra/rb are rollover in the first and second cycle after the update edge.
   task automatic step(input logic ss, input logic clr, input logic lp, input logic tk,
                       output logic ra, output logic rb);
      tickIn = tk;
      @(negedge inClock);
      @(negedge inClock);
      startStop = ss;
      clear     = clr;
      lap       = lp;
      @(negedge inClock);
      ra        = rollover;
      startStop = 1'b0;
      clear     = 1'b0;
      lap       = 1'b0;
      tickIn    = 1'b0;
      @(negedge inClock);
      rb        = rollover;
      @(negedge inClock);
   endtask

   typedef struct {
      int          pre;
      logic        ss;
      logic        clr;
      logic        lp;
      logic        tk;
      logic [23:0] exp_dig;
      logic        exp_run;
      logic        exp_roll;
   } vec_t;

   vec_t vecs[21];

   initial begin
      logic ra, rb;
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      tickIn    = 1'b0;
      startStop = 1'b0;
      clear     = 1'b0;
      lap       = 1'b0;

      //          pre   ss clr lp tk  digits      run roll
      vecs[0]  = '{0,    1, 0, 0, 0, 24'h000000, 1, 0};
      vecs[1]  = '{0,    0, 0, 0, 1, 24'h000001, 1, 0};
      vecs[2]  = '{3,    0, 0, 0, 1, 24'h000005, 1, 0};
      vecs[3]  = '{0,    1, 0, 0, 0, 24'h000005, 0, 0};
      vecs[4]  = '{10,   0, 0, 0, 1, 24'h000005, 0, 0};
      vecs[5]  = '{0,    1, 0, 0, 0, 24'h000005, 1, 0};
      vecs[6]  = '{0,    0, 0, 0, 1, 24'h000006, 1, 0};
      vecs[7]  = '{0,    1, 0, 0, 1, 24'h000007, 0, 0};
      vecs[8]  = '{0,    1, 0, 0, 1, 24'h000007, 1, 0};
      vecs[9]  = '{94,   0, 0, 0, 1, 24'h000102, 1, 0};
      vecs[10] = '{0,    0, 1, 0, 0, 24'h000000, 0, 0};
      vecs[11] = '{0,    1, 0, 0, 0, 24'h000000, 1, 0};
      vecs[12] = '{1233, 0, 0, 0, 1, 24'h001234, 1, 0};
      vecs[13] = '{0,    1, 1, 1, 1, 24'h000000, 0, 0};
      vecs[14] = '{0,    1, 0, 0, 0, 24'h000000, 1, 0};
      vecs[15] = '{5998, 0, 0, 0, 1, 24'h005999, 1, 0};
      vecs[16] = '{0,    0, 0, 0, 1, 24'h010000, 1, 0};
      vecs[17] = '{5998, 0, 0, 0, 1, 24'h015999, 1, 0};
      vecs[18] = '{0,    0, 0, 0, 1, 24'h000000, 1, 1};
      vecs[19] = '{0,    0, 0, 0, 1, 24'h000001, 1, 0};
      vecs[20] = '{98,   0, 0, 0, 1, 24'h000100, 1, 0};

      // Reset state while reset is held.
      repeat (3) @(negedge inClock);
      chk("rst_digits",   32'(digits()),  32'h0);
      chk("rst_running",  32'(running),   32'h0);
      chk("rst_lap",      32'(lapActive), 32'h0);
      chk("rst_rollover", 32'(rollover),  32'h0);
      reset = 1'b1;
      repeat (4) @(negedge inClock);

      for (int i = 0; i < 21; i++) begin
         pre_ticks(vecs[i].pre);
         step(vecs[i].ss, vecs[i].clr, vecs[i].lp, vecs[i].tk, ra, rb);
         chk($sformatf("v%0d_digits", i),  32'(digits()),  32'(vecs[i].exp_dig));
         chk($sformatf("v%0d_running", i), 32'(running),   32'(vecs[i].exp_run));
         chk($sformatf("v%0d_lap", i),     32'(lapActive), 32'h0);
         chk($sformatf("v%0d_roll", i),    32'(ra),        32'(vecs[i].exp_roll));
         chk($sformatf("v%0d_roll_end", i), 32'(rb),       32'h0);
      end

      // Lap freeze: capture at 00:03.21, 50 ticks, release shows 00:03.71.
      step(1'b0, 1'b1, 1'b0, 1'b0, ra, rb);
      step(1'b1, 1'b0, 1'b0, 1'b0, ra, rb);
      pre_ticks(320);
      step(1'b0, 1'b0, 1'b0, 1'b1, ra, rb);
      chk("lap_pre_digits", 32'(digits()), 32'h000321);
      step(1'b0, 1'b0, 1'b1, 1'b0, ra, rb);
      chk("lap1_digits", 32'(digits()),  32'h000321);
      chk("lap1_active", 32'(lapActive), 32'(LAP_ON));
      pre_ticks(49);
      step(1'b0, 1'b0, 1'b0, 1'b1, ra, rb);
      chk("lap_hold_digits", 32'(digits()),  LAP_ON ? 32'h000321 : 32'h000371);
      chk("lap_hold_active", 32'(lapActive), 32'(LAP_ON));
      step(1'b0, 1'b0, 1'b1, 1'b0, ra, rb);
      chk("lap2_digits", 32'(digits()),  32'h000371);
      chk("lap2_active", 32'(lapActive), 32'h0);
      // Freeze again, pause, then a lap while paused releases it.
      step(1'b0, 1'b0, 1'b1, 1'b0, ra, rb);
      chk("lap3_active", 32'(lapActive), 32'(LAP_ON));
      step(1'b1, 1'b0, 1'b0, 1'b0, ra, rb);
      chk("lap_pause_run",    32'(running),   32'h0);
      chk("lap_pause_active", 32'(lapActive), 32'(LAP_ON));
      step(1'b0, 1'b0, 1'b1, 1'b0, ra, rb);
      chk("lap_paused_clear", 32'(lapActive), 32'h0);
      chk("lap_paused_digits", 32'(digits()), 32'h000371);

      // Reset mid-count with tickIn held high.
      step(1'b0, 1'b1, 1'b0, 1'b0, ra, rb);
      step(1'b1, 1'b0, 1'b0, 1'b0, ra, rb);
      pre_ticks(4566);
      step(1'b0, 1'b0, 1'b0, 1'b1, ra, rb);
      chk("pre_rst_digits", 32'(digits()), 32'h004567);
      tickIn = 1'b1;
      #5;
      reset = 1'b0;
      #1;
      chk("async_rst_digits",  32'(digits()), 32'h0);
      chk("async_rst_running", 32'(running),  32'h0);
      chk("async_rst_lap",     32'(lapActive), 32'h0);
      repeat (3) @(negedge inClock);
      reset = 1'b1;
      repeat (4) @(negedge inClock);
      startStop = 1'b1;
      @(negedge inClock);
      startStop = 1'b0;
      repeat (6) @(negedge inClock);
      chk("post_rst_running", 32'(running),  32'h1);
      chk("post_rst_high",    32'(digits()), 32'h0);
      tickIn = 1'b0;
      repeat (3) @(negedge inClock);
      chk("post_rst_low", 32'(digits()), 32'h0);
      tickIn = 1'b1;
      repeat (4) @(negedge inClock);
      chk("post_rst_rise", 32'(digits()), 32'h000001);
      tickIn = 1'b0;
      repeat (2) @(negedge inClock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
